aes_round_sched: RTL and testbench



---
 rtl/aes_round_sched_if.sv | 24 ++
 rtl/aes_round_sched.sv | 181 ++++++++++++++++++
 tb/tb_aes_round_sched.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sched_if.sv
// Block-side bus of aes_round_sched: input/output handshakes plus the
// round-key lookup port toward the external key-schedule store.
interface aes_round_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [127:0] data_in;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    modport slave (
        input  in_valid, mode, data_in, rk, out_ready,
        output in_ready, rk_idx, out_valid, data_out, busy
    );

    modport master (
        output in_valid, mode, data_in, rk, out_ready,
        input  in_ready, rk_idx, out_valid, data_out, busy
    );
endinterface

// File: rtl/aes_round_sched.sv
// Iterative AES round sequencer, one round per clock over a 128-bit state.
// Optional abort input enabled by defining AES_ROUND_SCHED_ABORT_EN.
module aes_round_sched #(
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              rst,
`ifdef AES_ROUND_SCHED_ABORT_EN
    input  logic              abort,
`endif
    aes_round_sched_if.slave  bus
);
    localparam logic [3:0] NR4 = 4'(NR);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [3:0]   round_q, round_d;
    logic         mode_q, mode_d;
    logic [3:0]   rk_idx;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Field inverse as a^254 (0 maps to 0), which keeps the S-boxes table-free.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
        logic [7:0] v;
        if (inv) begin
            v = gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
        end else begin
            v = gf_inv(a);
            v = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
        end
        return v;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8], inv);
        return o;
    endfunction

    // Byte k = row + 4*col; row r rotates left by r (right by r when inverse).
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] mcoef(input logic inv, input int d);
        logic [7:0] v;
        case (d)
            0:       v = inv ? 8'h0e : 8'h02;
            1:       v = inv ? 8'h0b : 8'h03;
            2:       v = inv ? 8'h0d : 8'h01;
            default: v = inv ? 8'h09 : 8'h01;
        endcase
        return v;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(mcoef(inv, (j - r + 4) % 4), s[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    logic [127:0] enc_sr, enc_mc, dec_ark, dec_mc;
    logic         last;

    assign enc_sr  = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
    assign enc_mc  = mix_cols(enc_sr, 1'b0);
    assign dec_ark = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ bus.rk;
    assign dec_mc  = mix_cols(dec_ark, 1'b1);
    assign last    = (round_q == NR4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        round_d = round_q;
        mode_d  = mode_q;
        rk_idx  = '0;
        case (state_q)
            IDLE: begin
                // Key index follows the live mode input so the whitening key is ready at accept.
                rk_idx = bus.mode ? NR4 : 4'd0;
                if (bus.in_valid) begin
                    st_d    = bus.data_in ^ bus.rk;
                    mode_d  = bus.mode;
                    round_d = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                rk_idx = mode_q ? NR4 - round_q : round_q;
                if (mode_q) st_d = last ? dec_ark : dec_mc;
                else        st_d = (last ? enc_sr : enc_mc) ^ bus.rk;
                round_d = round_q + 4'd1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AES_ROUND_SCHED_ABORT_EN
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            st_d    = '0;
            round_d = '0;
        end
`endif
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.data_out  = st_q;
    assign bus.rk_idx    = rk_idx;
endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: FIPS-197 vectors, random blocks against a
// byte-level AES model, backpressure, back-to-back, reset and abort cases.
module tb_aes_round_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_round_sched_if bus();
    logic [127:0] rks [0:14];
    assign bus.rk = rks[bus.rk_idx];

`ifdef AES_ROUND_SCHED_ABORT_EN
    logic abort = 1'b0;
`endif

    aes_round_sched #(.NR(10)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef AES_ROUND_SCHED_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    // S-box tables built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        while (b != 8'h00) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] mc(input bit dec, input int d);
        logic [7:0] e [4];
        logic [7:0] v [4];
        e = '{8'h02, 8'h03, 8'h01, 8'h01};
        v = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        return dec ? v[d] : e[d];
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 11; r < 15; r++) rks[r] = '0;
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] din, input bit dec);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   acc;
        logic [127:0] kw, o;
        int rd, src;
        kw = rks[dec ? 10 : 0];
        for (int i = 0; i < 16; i++) s[i] = din[127-8*i -: 8] ^ kw[127-8*i -: 8];
        for (int n = 1; n <= 10; n++) begin
            rd = dec ? 10 - n : n;
            kw = rks[rd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    src = dec ? (c - r + 4) % 4 : (c + r) % 4;
                    t[r+4*c] = dec ? isb[s[r+4*src]] : sb[s[r+4*src]];
                end
            if (dec) for (int i = 0; i < 16; i++) t[i] = t[i] ^ kw[127-8*i -: 8];
            if (n < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gm(mc(dec, (j - r + 4) % 4), t[4*c+j]);
                        s[4*c+r] = acc;
                    end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            if (!dec) for (int i = 0; i < 16; i++) s[i] = s[i] ^ kw[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Full block through the DUT, starting and ending at a negedge in IDLE.
    task automatic do_block(input string nm, input bit m, input logic [127:0] din,
                            input logic [127:0] exp);
        int lat;
        bit seq_ok;
        logic [3:0] want;
        chk({nm, " in_ready"}, 128'(bus.in_ready), 128'd1);
        bus.mode = m; bus.data_in = din; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        #1;
        seq_ok = (bus.rk_idx == (m ? 4'd10 : 4'd0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            want = m ? 4'(10 - lat) : 4'(lat);
            if (bus.rk_idx !== want) seq_ok = 1'b0;
            bus.mode = 1'($urandom);
            bus.data_in = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 128'(lat), 128'd11);
        chk({nm, " rk_seq"}, 128'(seq_ok), 128'd1);
        chk({nm, " data_out"}, bus.data_out, exp);
        chk({nm, " busy"}, 128'(bus.busy), 128'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({nm, " released"}, 128'({bus.out_valid, bus.in_ready}), 128'b01);
        chk({nm, " retained"}, bus.data_out, exp);
    endtask

    task automatic start_enc(input logic [127:0] din, input logic [3:0] stop_idx);
        int cnt;
        bus.mode = 1'b0; bus.data_in = din; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cnt = 1;
        while (bus.rk_idx != stop_idx && !bus.out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    typedef struct {
        logic [127:0] key;
        bit           m;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [4];
        logic [127:0] blk [3];
        bit md [3];
        int acc [3];
        logic [127:0] got [$];
        logic [127:0] d;
        bit m, ok;
        int nacc, cyc;

        tbl[0] = '{K1, 1'b0, P1, C1};
        tbl[1] = '{K1, 1'b1, C1, P1};
        tbl[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0,
                   128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        tbl[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1,
                   128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};

        build_sbox();
        set_key(K1);
        bus.in_valid = 1'b0; bus.mode = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;

        #1;
        chk("rst in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst busy", 128'(bus.busy), 128'd0);
        chk("rst data_out", bus.data_out, 128'd0);
        chk("rst rk_idx", 128'(bus.rk_idx), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            set_key(tbl[i].key);
            do_block($sformatf("vec%0d", i), tbl[i].m, tbl[i].din, tbl[i].dout);
        end

        for (int i = 0; i < 20; i++) begin
            set_key({$urandom, $urandom, $urandom, $urandom});
            m = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom, $urandom, $urandom};
            do_block($sformatf("rand%0d", i), m, d, ref_aes(d, m));
        end

        // Backpressure: result must hold while out_ready stays low.
        set_key(K1);
        start_enc(P1, 4'hf);
        chk("bp reach", 128'(bus.out_valid), 128'd1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.data_out !== C1 || bus.in_ready !== 1'b0) ok = 1'b0;
        end
        chk("bp hold", 128'(ok), 128'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp release", 128'({bus.out_valid, bus.in_ready}), 128'b01);

        // Back-to-back with in_valid held and inputs churning mid-flight.
        for (int i = 0; i < 3; i++) begin
            blk[i] = {$urandom, $urandom, $urandom, $urandom};
            md[i] = 1'($urandom_range(0, 1));
            acc[i] = 0;
        end
        nacc = 0;
        cyc = 0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        while (got.size() < 3 && cyc < 80) begin
            if (bus.out_valid) got.push_back(bus.data_out);
            if (bus.in_ready && nacc < 3) begin
                bus.data_in = blk[nacc]; bus.mode = md[nacc]; acc[nacc] = cyc; nacc++;
            end else begin
                bus.data_in = {$urandom, $urandom, $urandom, $urandom};
                bus.mode = 1'($urandom);
                if (nacc == 3) bus.in_valid = 1'b0;
            end
            if (got.size() < 3) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        chk("b2b count", 128'(got.size()), 128'd3);
        chk("b2b gap0", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b gap1", 128'(acc[2] - acc[1]), 128'd12);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b data%0d", i), (got.size() > i) ? got[i] : 'x, ref_aes(blk[i], md[i]));

        // Asynchronous reset in the middle of round 5.
        start_enc(P1, 4'd5);
        chk("rst5 at round", 128'(bus.rk_idx), 128'd5);
        rst = 1'b1;
        #1;
        chk("rst5 out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst5 in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst5 data_out", bus.data_out, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        do_block("post_rst", 1'b0, P1, C1);

`ifdef AES_ROUND_SCHED_ABORT_EN
        start_enc(P1, 4'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort3 idle", 128'({bus.in_ready, bus.busy}), 128'b10);
        chk("abort3 data_out", bus.data_out, 128'd0);
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) ok = 1'b0;
        end
        chk("abort3 no_out", 128'(ok), 128'd1);
        start_enc(P1, 4'hf);
        chk("abortd reach", 128'(bus.out_valid), 128'd1);
        abort = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; bus.out_ready = 1'b0;
        chk("abortd idle", 128'({bus.out_valid, bus.in_ready}), 128'b01);
        chk("abortd data_out", bus.data_out, 128'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
